// File: rtl/mont_mul_pipe_if.sv
// mont_mul_pipe_if -- bus bundle for the pipelined Montgomery multiplier.
//
// Groups the configuration port, the operand (in_*) handshake, the result
// (out_*) handshake and the busy status into one interface.
//   master : the side that supplies operands/config and consumes results
//   slave  : the multiplier itself
//
// Signals:
//   cfg_we, cfg_m[W], cfg_minv[M_BITS]   modulus / M' load request
//   cfg_err                              write dropped because the pipe was busy
//   in_valid, in_ready, in_a, in_b, in_tag
//   out_valid, out_ready, out_s, out_tag
//   busy                                 any stage holds a live operation
interface mont_mul_pipe_if #(
    parameter int W      = 32,
    parameter int M_BITS = 8,
    parameter int TAG_W  = 4
);
    logic              cfg_we;
    logic [W-1:0]      cfg_m;
    logic [M_BITS-1:0] cfg_minv;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_s;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output cfg_we, cfg_m, cfg_minv, in_valid, in_a, in_b, in_tag, out_ready,
        input  cfg_err, in_ready, out_valid, out_s, out_tag, busy
    );

    modport slave (
        input  cfg_we, cfg_m, cfg_minv, in_valid, in_a, in_b, in_tag, out_ready,
        output cfg_err, in_ready, out_valid, out_s, out_tag, busy
    );
endinterface

// File: rtl/mont_mul_pipe.sv
// mont_mul_pipe -- digit-serial pipelined Montgomery multiplier.
//
// Computes out_s = A * B * R^-1 mod M with R = 2^W. One pipeline stage per
// M_BITS digit of A, so N = W / M_BITS stages and a latency of N cycles.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   mont_mul_pipe_if.slave (config, operand and result handshakes, busy)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready does not depend on in_valid; out_valid does not depend
// on out_ready. While out_valid is high and out_ready low, out_s/out_tag hold.
//
// Optional feature: define MONT_MUL_LAZY_RED_EN to drop the final
// conditional subtract, leaving out_s in [0, 2M).
module mont_mul_pipe #(
    parameter  int W      = 32,
    parameter  int M_BITS = 8,
    parameter  int TAG_W  = 4,
    localparam int N      = W / M_BITS
) (
    input  logic          clk,
    input  logic          rst,
    mont_mul_pipe_if.slave bus
);
    // Room for s + ai*b + q*M plus one spare bit so nothing can wrap.
    localparam int T = W + M_BITS + 2;

    logic [N-1:0]       vld_q;
    logic [W:0]         s_q   [N];
    logic [W-1:0]       a_q   [N];
    logic [W-1:0]       b_q   [N];
    logic [TAG_W-1:0]   tag_q [N];
    logic [W:0]         s_nxt [N];

    logic [W-1:0]       m_q;
    logic [M_BITS-1:0]  minv_q;
    logic               cfg_err_q;

    logic               en;
    logic               busy_int;
    logic               cfg_ok;
    logic [W-1:0]       m_use;
    logic [M_BITS-1:0]  minv_use;

    assign busy_int = |vld_q;
    assign en       = !vld_q[N-1] | bus.out_ready;
    assign cfg_ok   = bus.cfg_we & ~busy_int;

    // A config write on an idle pipe takes effect for an operand accepted in
    // the same cycle; when idle no other stage is live, so every stage can
    // use the bypassed value.
    assign m_use    = cfg_ok ? bus.cfg_m    : m_q;
    assign minv_use = cfg_ok ? bus.cfg_minv : minv_q;

    // One Montgomery digit step per stage: t = s + ai*b,
    // q = t*M' mod 2^M_BITS, s' = (t + q*M) / 2^M_BITS (exact division).
    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [W:0]        s_in;
        logic [W-1:0]      b_in;
        logic [M_BITS-1:0] digit;
        logic [M_BITS-1:0] q;
        logic [T-1:0]      t;
        logic [T-1:0]      sum;

        if (k == 0) begin : g_first
            assign s_in  = '0;
            assign b_in  = bus.in_b;
            assign digit = bus.in_a[0 +: M_BITS];
        end else begin : g_rest
            assign s_in  = s_q[k-1];
            assign b_in  = b_q[k-1];
            assign digit = a_q[k-1][k*M_BITS +: M_BITS];
        end

        assign t        = T'(s_in) + T'(digit) * T'(b_in);
        assign q        = t[M_BITS-1:0] * minv_use;
        assign sum      = t + T'(q) * T'(m_use);
        assign s_nxt[k] = (W+1)'(sum >> M_BITS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            m_q       <= '0;
            minv_q    <= '0;
            cfg_err_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                s_q[k]   <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            cfg_err_q <= bus.cfg_we & busy_int;
            if (cfg_ok) begin
                m_q    <= bus.cfg_m;
                minv_q <= bus.cfg_minv;
            end
            if (en) begin
                // With en high, in_ready is high, so in_valid alone decides
                // whether stage 0 takes an operand or a bubble.
                vld_q[0] <= bus.in_valid;
                a_q[0]   <= bus.in_a;
                b_q[0]   <= bus.in_b;
                tag_q[0] <= bus.in_tag;
                for (int k = 1; k < N; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    a_q[k]   <= a_q[k-1];
                    b_q[k]   <= b_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
                for (int k = 0; k < N; k++) begin
                    s_q[k] <= s_nxt[k];
                end
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[N-1];
    assign bus.out_tag   = tag_q[N-1];
    assign bus.busy      = busy_int;
    assign bus.cfg_err   = cfg_err_q;

`ifdef MONT_MUL_LAZY_RED_EN
    assign bus.out_s = W'(s_q[N-1]);
`else
    assign bus.out_s = W'((s_q[N-1] >= {1'b0, m_q}) ? (s_q[N-1] - {1'b0, m_q}) : s_q[N-1]);
`endif

    // Last-stage copies of a/b are carried only for pipeline regularity.
    logic unused_bits;
    assign unused_bits = ^{a_q[N-1], b_q[N-1], s_q[N-1][W]};
endmodule

// File: tb/tb_mont_mul_pipe.sv
// tb_mont_mul_pipe -- self-checking bench for mont_mul_pipe (W=16, M_BITS=4).
//
// Reference model computes A*B*R^-1 mod M with plain modular arithmetic.
// Expected results are queued on accept and popped by a monitor whenever
// the DUT hands over a result.
module tb_mont_mul_pipe;
    localparam int W  = 16;
    localparam int MB = 4;
    localparam int TW = 4;
    localparam int N  = W / MB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mont_mul_pipe_if #(.W(W), .M_BITS(MB), .TAG_W(TW)) bus ();

    mont_mul_pipe #(.W(W), .M_BITS(MB), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [W-1:0]  exp_q [$];
    logic [TW-1:0] tag_q [$];
    int unsigned   mod_q [$];

    int unsigned cur_m = 0;
    int          run = 0;
    int          max_run = 0;

    // ---------------- reference model ----------------
    function automatic int unsigned ref_mont(input int unsigned a, input int unsigned b,
                                             input int unsigned m);
        longint unsigned rinv = 0;
        longint unsigned p;
        for (longint unsigned x = 1; x < m; x++) begin
            if (((x * 65536) % m) == 1) begin
                rinv = x;
                break;
            end
        end
        p = (longint'(a) * longint'(b)) % m;
        return int'((p * rinv) % m);
    endfunction

    function automatic int unsigned calc_minv(input int unsigned m);
        int unsigned r = 0;
        for (int unsigned x = 0; x < 16; x++) begin
            if (((m * x + 1) % 16) == 0) r = x;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic ok, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0]  m_exp;
    logic [TW-1:0] m_tag;
    int unsigned   m_mod;
    logic          m_ok;

    always @(negedge clk) begin
        if (rst || !bus.out_valid) begin
            run = 0;
        end else if (bus.out_ready) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1'b0, longint'(bus.out_s), 0);
            end else begin
                m_exp = exp_q.pop_front();
                m_tag = tag_q.pop_front();
                m_mod = mod_q.pop_front();
`ifdef MONT_MUL_LAZY_RED_EN
                m_ok = (int'(bus.out_s) < 2 * m_mod) && ((int'(bus.out_s) % m_mod) == int'(m_exp));
`else
                m_ok = (bus.out_s == m_exp);
`endif
                check("result", m_ok, longint'(bus.out_s), longint'(m_exp));
                check("tag", bus.out_tag == m_tag, longint'(bus.out_tag), longint'(m_tag));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic send(input int unsigned a, input int unsigned b, input int unsigned tag,
                        output int tries);
        logic got;
        got = 1'b0;
        tries = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = W'(a);
        bus.in_b     = W'(b);
        bus.in_tag   = TW'(tag);
        while (!got && tries < 200) begin
            tries++;
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                exp_q.push_back(W'(ref_mont(a, b, cur_m)));
                tag_q.push_back(TW'(tag));
                mod_q.push_back(cur_m);
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 1'b0, tries, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int unsigned m);
        bus.cfg_we   = 1'b1;
        bus.cfg_m    = W'(m);
        bus.cfg_minv = MB'(calc_minv(m));
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (bus.busy && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("idle", !bus.busy, bus.busy, 0);
    endtask

    // ---------------- stimulus ----------------
    int   tries;
    int   lat;
    logic rand_done;
    logic [W-1:0]  held_s;
    logic [TW-1:0] held_tag;
    logic stale;

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_m     = '0;
        bus.cfg_minv  = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready == 1'b1,  bus.in_ready, 1);
        check("rst_busy",      bus.busy == 1'b0,      bus.busy, 0);
        check("rst_cfg_err",   bus.cfg_err == 1'b0,   bus.cfg_err, 0);
        check("rst_out_s",     bus.out_s == '0,       bus.out_s, 0);
        check("rst_out_tag",   bus.out_tag == '0,     bus.out_tag, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cur_m = 97;
        cfg_write(97);

        // Latency of a single op on an idle pipe.
        send(61, 61, 3, tries);
        lat = 0;
        while (lat < 20) begin
            lat++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check("latency", lat == N, lat, N);
        @(posedge clk);
        #1;
        drain();

        // Identity and zero cases.
        send(1, 1, 5, tries);
        send(0, 96, 6, tries);
        drain();

        // Back-to-back stream.
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send($urandom_range(0, cur_m - 1), $urandom_range(0, cur_m - 1), i, tries);
            check("stream_accept", tries == 1, tries, 1);
        end
        drain();
        check("stream_run", max_run >= 8, max_run, 8);

        // Backpressure: fill the pipe and hold.
        wait_idle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            send($urandom_range(0, cur_m - 1), $urandom_range(0, cur_m - 1), 8 + i, tries);
            check("fill_accept", tries == 1, tries, 1);
        end
        @(negedge clk);
        held_s   = bus.out_s;
        held_tag = bus.out_tag;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready",  bus.in_ready == 1'b0,  bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
            check("stall_out_s",     bus.out_s == held_s,   bus.out_s, held_s);
            check("stall_out_tag",   bus.out_tag == held_tag, bus.out_tag, held_tag);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Config write while busy is dropped.
        send(10, 20, 1, tries);
        bus.cfg_we   = 1'b1;
        bus.cfg_m    = W'(113);
        bus.cfg_minv = MB'(calc_minv(113));
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", bus.cfg_err == 1'b1, bus.cfg_err, 1);
        @(negedge clk);
        check("cfg_err_clear", bus.cfg_err == 1'b0, bus.cfg_err, 0);
        @(posedge clk);
        #1;
        send(30, 40, 2, tries);
        drain();

        // Config write while idle applies to an op accepted in the same cycle.
        wait_idle();
        cur_m        = 113;
        bus.cfg_we   = 1'b1;
        bus.cfg_m    = W'(113);
        bus.cfg_minv = MB'(calc_minv(113));
        send(109, 109, 7, tries);
        bus.cfg_we = 1'b0;
        drain();
        wait_idle();
        cur_m = 97;
        cfg_write(97);

        // Randomised traffic with bubbles and random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom_range(0, cur_m - 1), $urandom_range(0, cur_m - 1),
                         $urandom_range(0, 15), tries);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with operations in flight.
        wait_idle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(i + 2, i + 3, i, tries);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_reset_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("reset_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        check("reset_busy",      bus.busy == 1'b0,      bus.busy, 0);
        exp_q.delete();
        tag_q.delete();
        mod_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("no_stale_output", stale == 1'b0, stale, 0);
        @(posedge clk);
        #1;
        cur_m = 97;
        cfg_write(97);
        send(1, 1, 9, tries);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
        $fatal(1, "watchdog");
    end
endmodule
